// File: rtl/multi_pselect_dir1_reg_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : multi_pselect_dir1_reg_pkg
// Purpose  : Shared constants and helpers for the registered multi-grant
//            circular priority selector.
// Contents : c_MODE_AGE / c_MODE_RR start-pointer source selectors,
//            wrap_inc() index advance with wrap at an arbitrary N,
//            default queue depth macro and maximum grant width macro.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------

`ifndef SQ_SIZE
`define SQ_SIZE 8
`endif

// Upper bound on grants per capture; checked by the top-level assertions.
`ifndef MPSEL_MAX_W
`define MPSEL_MAX_W 8
`endif

package multi_pselect_dir1_reg_pkg;

   localparam int c_MODE_AGE = 0;   // start pointer taken from sel
   localparam int c_MODE_RR  = 1;   // start pointer taken from internal rr_ptr

   // Advance an index by one, wrapping at n rather than at a power of two.
   function automatic int wrap_inc(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/multi_pselect_dir1_reg_rot_first_set.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : rot_first_set
// Purpose  : Finds the first set bit of (req & ~mask), scanning upward from
//            start with wrap-around at N.
// Ports    : req   - request vector
//            start - scan start index (expected < N)
//            mask  - bits already granted by earlier stages
//            found - a live bit exists
//            idx   - binary index of that bit (0 when none found)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module rot_first_set
   import multi_pselect_dir1_reg_pkg::*;
#(
   parameter  int N  = 8,
   localparam int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] start,
   input  logic [N-1:0]  mask,
   output logic          found,
   output logic [IW-1:0] idx
);

   logic [N-1:0] w_live;

   assign w_live = req & ~mask;

   always_comb begin
      logic [IW-1:0] w_pos;
      found = 1'b0;
      idx   = '0;
      w_pos = start;
      for (int i = 0; i < N; i++) begin
         if (!found && w_live[w_pos]) begin
            found = 1'b1;
            idx   = w_pos;
         end
         // Wrap at N explicitly; N need not be a power of two.
         w_pos = (w_pos == IW'(N - 1)) ? '0 : w_pos + IW'(1);
      end
   end

endmodule

`default_nettype wire

// File: rtl/multi_pselect_dir1_reg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : multi_pselect_dir1_reg
// Purpose  : Registered multi-grant circular priority selector. Picks the
//            first W set bits of req in scan order starting at a pointer
//            (sel in MODE 0, internal rr_ptr in MODE 1) and presents them
//            behind a one-deep valid/ready output register.
// Ports    : clock/reset        - rising-edge clock, async active-low reset
//            req, en, sel       - request vector, capture enable, start index
//            in_ready           - a capture happens at the next edge
//            out_valid/out_ready- output handshake
//            gnt_idx/gnt_vld    - per-slot index and thermometer valid
//            gnt_mask           - one-hot OR of valid grants
//            rr_ptr             - round-robin pointer (0 in MODE 0)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module multi_pselect_dir1_reg
   import multi_pselect_dir1_reg_pkg::*;
#(
   parameter  int N    = `SQ_SIZE,
   parameter  int W    = 2,
   parameter  int MODE = 0,
   localparam int IW   = $clog2(N)
) (
   input  logic            clock,
   input  logic            reset,
   input  logic [N-1:0]    req,
   input  logic            en,
   input  logic [IW-1:0]   sel,
   output logic            in_ready,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [W*IW-1:0] gnt_idx,
   output logic [W-1:0]    gnt_vld,
   output logic [N-1:0]    gnt_mask,
   output logic [IW-1:0]   rr_ptr
);

   logic [IW-1:0]          w_start;
   logic [W-1:0]           w_found;
   logic [W-1:0][IW-1:0]   w_idx;
   logic [N-1:0]           w_mask_all;
   logic [IW-1:0]          w_last;
   logic [IW-1:0]          w_rr_next;
   logic                   w_vld_next;

   logic                   r_out_valid;
   logic [W*IW-1:0]        r_gnt_idx;
   logic [W-1:0]           r_gnt_vld;
   logic [N-1:0]           r_gnt_mask;
   logic [IW-1:0]          r_rr_ptr;

   // Out-of-range sel falls back to index 0.
   assign w_start = (MODE == c_MODE_RR) ? r_rr_ptr
                  : ((int'(sel) >= N) ? '0 : sel);

   // Stage k sees the grants of stages 0..k-1 as a mask, so slot k is the
   // (k+1)-th set bit in scan order and unused slots trail as zeros.
   for (genvar k = 0; k < W; k++) begin : g_stage
      logic [N-1:0]  w_mask_in;
      logic [N-1:0]  w_mask_out;
      logic          w_stage_found;
      logic [IW-1:0] w_stage_idx;

      if (k == 0) begin : g_first
         assign w_mask_in = '0;
      end else begin : g_next
         assign w_mask_in = g_stage[k-1].w_mask_out;
      end

      rot_first_set #(.N(N)) u_rot_first_set (
         .req   (req),
         .start (w_start),
         .mask  (w_mask_in),
         .found (w_stage_found),
         .idx   (w_stage_idx)
      );

      assign w_mask_out = w_mask_in | (w_stage_found ? (N'(1) << w_stage_idx) : '0);
      assign w_found[k] = w_stage_found;
      assign w_idx[k]   = w_stage_idx;
   end

   assign w_mask_all = g_stage[W-1].w_mask_out;

   // Index of the last valid slot; the round-robin pointer resumes after it.
   always_comb begin
      w_last = '0;
      for (int k = 0; k < W; k++) begin
         if (w_found[k]) begin
            w_last = w_idx[k];
         end
      end
   end

   assign w_rr_next  = IW'(wrap_inc(int'(w_last), N));
   assign w_vld_next = en && (|req);
   assign in_ready   = !r_out_valid || out_ready;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_out_valid <= 1'b0;
         r_gnt_idx   <= '0;
         r_gnt_vld   <= '0;
         r_gnt_mask  <= '0;
         r_rr_ptr    <= '0;
      end else if (in_ready) begin
         r_out_valid <= w_vld_next;
         r_gnt_idx   <= en ? w_idx      : '0;
         r_gnt_vld   <= en ? w_found    : '0;
         r_gnt_mask  <= en ? w_mask_all : '0;
         if ((MODE == c_MODE_RR) && w_vld_next) begin
            r_rr_ptr <= w_rr_next;
         end
      end
   end

   assign out_valid = r_out_valid;
   assign gnt_idx   = r_gnt_idx;
   assign gnt_vld   = r_gnt_vld;
   assign gnt_mask  = r_gnt_mask;
   assign rr_ptr    = r_rr_ptr;

`ifndef SYNTHESIS
   always_ff @(posedge clock) begin
      if (reset) begin
         a_w_range : assert ((W >= 1) && (W <= N) && (W <= `MPSEL_MAX_W));
         a_thermo  : assert ((r_gnt_vld & (r_gnt_vld + W'(1))) == '0);
         for (int a = 0; a < W; a++) begin
            for (int b = a + 1; b < W; b++) begin
               if (r_gnt_vld[a] && r_gnt_vld[b]) begin
                  assert (r_gnt_idx[a*IW +: IW] != r_gnt_idx[b*IW +: IW]);
               end
            end
         end
      end
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_multi_pselect_dir1_reg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_multi_pselect_dir1_reg
// Purpose  : Scoreboard bench for three selector configurations:
//            dut 0: N=8 W=2 MODE 0, dut 1: N=6 W=2 MODE 0, dut 2: N=8 W=2 MODE 1
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_multi_pselect_dir1_reg;

   typedef struct packed {
      logic [5:0] idx;
      logic [1:0] vld;
      logic [7:0] mask;
      logic [2:0] rr;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] req [3];
   logic [2:0] sel [3];
   logic       en  [3];
   logic       rdy [3];
   logic       in_ready  [3];
   logic       out_valid [3];
   logic [5:0] gidx [3];
   logic [1:0] gvld [3];
   logic [2:0] rrp  [3];
   logic [7:0] mask_a, mask_c;
   logic [5:0] mask_b;

   logic       mv  [3];
   int         mrr [3];
   exp_t       q0[$], q1[$], q2[$];
   int         n_chk  = 0;
   int         n_fail = 0;

   always #5 clk = ~clk;

   multi_pselect_dir1_reg #(.N(8), .W(2), .MODE(0)) u_dut_a (
      .clock(clk), .reset(rst_n), .req(req[0]), .en(en[0]), .sel(sel[0]),
      .in_ready(in_ready[0]), .out_valid(out_valid[0]), .out_ready(rdy[0]),
      .gnt_idx(gidx[0]), .gnt_vld(gvld[0]), .gnt_mask(mask_a), .rr_ptr(rrp[0]));

   multi_pselect_dir1_reg #(.N(6), .W(2), .MODE(0)) u_dut_b (
      .clock(clk), .reset(rst_n), .req(req[1][5:0]), .en(en[1]), .sel(sel[1]),
      .in_ready(in_ready[1]), .out_valid(out_valid[1]), .out_ready(rdy[1]),
      .gnt_idx(gidx[1]), .gnt_vld(gvld[1]), .gnt_mask(mask_b), .rr_ptr(rrp[1]));

   multi_pselect_dir1_reg #(.N(8), .W(2), .MODE(1)) u_dut_c (
      .clock(clk), .reset(rst_n), .req(req[2]), .en(en[2]), .sel(sel[2]),
      .in_ready(in_ready[2]), .out_valid(out_valid[2]), .out_ready(rdy[2]),
      .gnt_idx(gidx[2]), .gnt_vld(gvld[2]), .gnt_mask(mask_c), .rr_ptr(rrp[2]));

   function automatic int n_of(input int d);
      return (d == 1) ? 6 : 8;
   endfunction

   function automatic bit rr_mode(input int d);
      return (d == 2);
   endfunction

   function automatic logic [7:0] act_mask(input int d);
      return (d == 0) ? mask_a : (d == 1) ? {2'b00, mask_b} : mask_c;
   endfunction

   // Reference: walk the request lines in circular order from the start
   // pointer and take the first two set ones.
   function automatic exp_t model(input int d, input logic [7:0] r, input logic [2:0] s,
                                  input int rr, output int rr_next);
      exp_t e;
      int   n;
      int   p;
      int   cnt;
      n   = n_of(d);
      e   = '0;
      cnt = 0;
      rr_next = rr;
      p = rr_mode(d) ? rr : ((int'(s) >= n) ? 0 : int'(s));
      for (int i = 0; i < n; i++) begin
         int j;
         j = (p + i) % n;
         if (r[j] && cnt < 2) begin
            e.idx[cnt*3 +: 3] = 3'(j);
            e.vld[cnt]        = 1'b1;
            e.mask[j]         = 1'b1;
            cnt++;
            if (rr_mode(d)) rr_next = (j + 1) % n;
         end
      end
      e.rr = rr_mode(d) ? 3'(rr_next) : 3'd0;
      return e;
   endfunction

   task automatic check(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s dut%0d: got %0h, expected %0h at %0t", nm, d, act, exp, $time);
      end
   endtask

   task automatic push(input int d, input exp_t e);
      if (d == 0) q0.push_back(e);
      else if (d == 1) q1.push_back(e);
      else q2.push_back(e);
   endtask

   function automatic int qsize(input int d);
      return (d == 0) ? q0.size() : (d == 1) ? q1.size() : q2.size();
   endfunction

   function automatic exp_t pop(input int d);
      if (d == 0) return q0.pop_front();
      else if (d == 1) return q1.pop_front();
      else return q2.pop_front();
   endfunction

   task automatic set_in(input int d, input logic [7:0] r, input logic [2:0] s,
                         input logic e, input logic rd);
      req[d] = (d == 1) ? (r & 8'h3F) : r;
      sel[d] = s;
      en[d]  = e;
      rdy[d] = rd;
   endtask

   // One clock: check handshake state against the model, decide whether the
   // coming edge captures, and enqueue the expected result if it does.
   task automatic step();
      logic nmv [3];
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         check("out_valid", d, 32'(out_valid[d]), 32'(mv[d]));
         check("in_ready", d, 32'(in_ready[d]), 32'(!mv[d] || rdy[d]));
         nmv[d] = mv[d];
         if (!mv[d] || rdy[d]) begin
            nmv[d] = en[d] && (|req[d]);
            if (nmv[d]) begin
               int   rn;
               exp_t e;
               e = model(d, req[d], sel[d], mrr[d], rn);
               push(d, e);
               mrr[d] = rn;
            end
         end
      end
      @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) mv[d] = nmv[d];
   endtask

   // Monitor: every accepted result is compared against the oldest expectation.
   always @(negedge clk) begin
      if (rst_n) begin
         for (int d = 0; d < 3; d++) begin
            if (out_valid[d] && rdy[d]) begin
               exp_t e;
               if (qsize(d) == 0) begin
                  n_chk++;
                  n_fail++;
                  $display("FAIL unexpected_output dut%0d: got idx %0h, expected no result", d, gidx[d]);
               end else begin
                  e = pop(d);
                  check("gnt_idx",  d, 32'(gidx[d]),    32'(e.idx));
                  check("gnt_vld",  d, 32'(gvld[d]),    32'(e.vld));
                  check("gnt_mask", d, 32'(act_mask(d)), 32'(e.mask));
                  check("rr_ptr",   d, 32'(rrp[d]),     32'(e.rr));
               end
            end
         end
      end
   end

   initial begin
      rst_n = 1'b0;
      for (int d = 0; d < 3; d++) begin
         set_in(d, 8'h00, 3'd0, 1'b0, 1'b1);
         mv[d]  = 1'b0;
         mrr[d] = 0;
      end
      #2;
      for (int d = 0; d < 3; d++) begin
         check("rst_out_valid", d, 32'(out_valid[d]), 0);
         check("rst_gnt_vld",   d, 32'(gvld[d]),      0);
         check("rst_gnt_mask",  d, 32'(act_mask(d)),  0);
         check("rst_rr_ptr",    d, 32'(rrp[d]),       0);
      end
      #10 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Directed: age-order wrap cases plus round-robin rotation over all-ones.
      for (int k = 0; k < 5; k++) begin
         set_in(2, 8'hFF, 3'd0, 1'b1, 1'b1);
         if (k == 0) begin
            set_in(0, 8'b0010_0101, 3'd5, 1'b1, 1'b1);
            set_in(1, 8'b0010_0001, 3'd5, 1'b1, 1'b1);
         end else if (k == 1) begin
            set_in(0, 8'h00, 3'd0, 1'b0, 1'b1);
            set_in(1, 8'b0000_0100, 3'd7, 1'b1, 1'b1);
         end else begin
            set_in(0, 8'h00, 3'd0, 1'b0, 1'b1);
            set_in(1, 8'h00, 3'd0, 1'b0, 1'b1);
         end
         step();
         check("rr_seq", 2, 32'(rrp[2]), ((k + 1) * 2) % 8);
         check("rr_pair", 2, 32'(gidx[2]), 32'({3'((2 * k + 1) % 8), 3'((2 * k) % 8)}));
         if (k == 0) begin
            check("a_idx",  0, 32'(gidx[0]), 32'(6'b000_101));
            check("a_vld",  0, 32'(gvld[0]), 32'(2'b11));
            check("a_mask", 0, 32'(mask_a),  32'(8'h21));
            check("b_wrap_idx", 1, 32'(gidx[1]), 32'(6'b000_101));
         end
         if (k == 1) begin
            check("b_oor_idx", 1, 32'(gidx[1]), 32'(6'b000_010));
            check("b_oor_vld", 1, 32'(gvld[1]), 32'(2'b01));
         end
      end

      // Single request in round-robin mode, then a disabled capture.
      set_in(2, 8'b0100_0000, 3'd0, 1'b1, 1'b1);
      step();
      check("single_rr",  2, 32'(rrp[2]), 7);
      check("single_vld", 2, 32'(gvld[2]), 32'(2'b01));
      check("single_idx", 2, 32'(gidx[2]), 6);
      set_in(2, 8'hFF, 3'd3, 1'b0, 1'b1);
      step();
      check("en0_vld", 2, 32'(gvld[2]), 0);
      check("en0_rr",  2, 32'(rrp[2]), 7);

      // Stall for three cycles with inputs toggling, then pass-through.
      for (int d = 0; d < 3; d++) set_in(d, 8'($urandom) | 8'h01, 3'($urandom), 1'b1, 1'b1);
      step();
      for (int c = 0; c < 3; c++) begin
         for (int d = 0; d < 3; d++) set_in(d, 8'($urandom), 3'($urandom), 1'b1, 1'b0);
         step();
      end
      for (int d = 0; d < 3; d++) set_in(d, 8'($urandom) | 8'h10, 3'($urandom), 1'b1, 1'b1);
      step();
      step();

      // Randomized traffic with random back-pressure and sparse/dense requests.
      for (int c = 0; c < 400; c++) begin
         for (int d = 0; d < 3; d++) begin
            logic [7:0] r;
            r = 8'($urandom);
            if ($urandom_range(0, 1) == 0) r = r & 8'($urandom) & 8'($urandom);
            set_in(d, r, 3'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) < 7));
         end
         step();
      end

      // Asynchronous reset in the middle of a stall.
      for (int d = 0; d < 3; d++) set_in(d, 8'b0000_1000, 3'd0, 1'b1, 1'b1);
      step();
      for (int d = 0; d < 3; d++) set_in(d, 8'hFF, 3'd1, 1'b1, 1'b0);
      step();
      check("pre_rst_rr",    2, 32'(rrp[2]), 4);
      check("pre_rst_valid", 2, 32'(out_valid[2]), 1);
      #2 rst_n = 1'b0;
      #1;
      for (int d = 0; d < 3; d++) begin
         check("async_rst_valid", d, 32'(out_valid[d]), 0);
         check("async_rst_vld",   d, 32'(gvld[d]), 0);
         check("async_rst_mask",  d, 32'(act_mask(d)), 0);
         check("async_rst_rr",    d, 32'(rrp[d]), 0);
         mv[d]  = 1'b0;
         mrr[d] = 0;
         set_in(d, 8'h00, 3'd0, 1'b1, 1'b1);
      end
      q0.delete();
      q1.delete();
      q2.delete();
      @(negedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;
      step();
      step();

      // Drain and confirm every expected result was presented.
      for (int d = 0; d < 3; d++) set_in(d, 8'h00, 3'd0, 1'b0, 1'b1);
      step();
      step();
      for (int d = 0; d < 3; d++) check("queue_empty", d, 32'(qsize(d)), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
